// File: rtl/fb_mem_arbiter_if.sv
// Requester-side and Avalon-MM signals of the frame-buffer arbiter.
// The arbiter takes the master modport; the requesters plus memory sit on the slave modport.
interface fb_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic [2:0]          req;
    logic                urgent;
    logic [2:0]          req_we;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*7-1:0]      req_len;
    logic [3*DATA_W-1:0] req_wdata;
    logic [2:0]          gnt;
    logic [2:0]          wr_ack;
    logic [2:0]          rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic                busy;
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [6:0]          avm_burstcount;
    logic                avm_waitrequest;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;

    modport master (
        input  req, urgent, req_we, req_addr, req_len, req_wdata,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output gnt, wr_ack, rd_valid, rd_data, busy,
        output avm_address, avm_read, avm_write, avm_writedata, avm_burstcount
    );

    modport slave (
        output req, urgent, req_we, req_addr, req_len, req_wdata,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  gnt, wr_ack, rd_valid, rd_data, busy,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_burstcount
    );
endinterface

// File: rtl/fb_mem_arbiter.sv
// Three-way frame-buffer arbiter (scanout/raster/CPU) onto one Avalon-MM burst master; FB_ARB_AGE_EN adds starvation ageing.
// Latency: req seen in IDLE -> gnt and avm command next cycle; re-arbitration the cycle after the last beat.
// Backpressure: avm_waitrequest freezes the command and wr_ack; read beats follow avm_readdatavalid.
module fb_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8,
    parameter int AGE_LIMIT = 64
) (
    input  logic             clk,
    input  logic             reset,
    fb_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        last_q, last_d;      // last winner; doubles as the current owner
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [6:0]        len_q, len_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [1:0]        win;
    logic              win_vld;
    logic [2:0]        own_oh;

    logic [ADDR_W-1:0] addr_a  [3];
    logic [6:0]        len_a   [3];
    logic [DATA_W-1:0] wdata_a [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            addr_a[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
            len_a[i]   = bus.req_len[i*7 +: 7];
            wdata_a[i] = bus.req_wdata[i*DATA_W +: DATA_W];
        end
    end

    function automatic logic [6:0] clamp_len(input logic [6:0] l);
        if (l == 7'd0)
            return 7'd1;
        if (l > 7'(MAX_BURST))
            return 7'(MAX_BURST);
        return l;
    endfunction

    assign own_oh = 3'b001 << last_q;

`ifdef FB_ARB_AGE_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    logic [AGE_W-1:0] age_q [3];
    logic [2:0]       aged;

    always_comb begin
        for (int i = 0; i < 3; i++)
            aged[i] = bus.req[i] && (age_q[i] >= AGE_W'(AGE_LIMIT));
    end

    // Counts only cycles spent waiting: cleared while not requesting, when winning, or while owning.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset || !bus.req[i]
                || (state_q != IDLE && last_q == 2'(i))
                || (state_q == IDLE && win_vld && win == 2'(i)))
                age_q[i] <= '0;
            else if (age_q[i] != AGE_W'(AGE_LIMIT))
                age_q[i] <= age_q[i] + AGE_W'(1);
        end
    end
`endif

    always_comb begin
        win_vld = |bus.req;
        case (last_q)
            2'd0:    win = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
            2'd1:    win = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
            default: win = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
        endcase
`ifdef FB_ARB_AGE_EN
        if (aged[0])
            win = 2'd0;
        else if (aged[1])
            win = 2'd1;
        else if (aged[2])
            win = 2'd2;
`endif
        if (bus.urgent && bus.req[0])
            win = 2'd0;
    end

    always_comb begin
        state_d            = state_q;
        last_d             = last_q;
        addr_d             = addr_q;
        we_d               = we_q;
        len_d              = len_q;
        cnt_d              = cnt_q;
        bus.gnt            = 3'b000;
        bus.wr_ack         = 3'b000;
        bus.rd_valid       = 3'b000;
        bus.rd_data        = '0;
        bus.busy           = (state_q != IDLE);
        bus.avm_address    = '0;
        bus.avm_read       = 1'b0;
        bus.avm_write      = 1'b0;
        bus.avm_writedata  = '0;
        bus.avm_burstcount = 7'd0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = CMD;
                    last_d  = win;
                    addr_d  = addr_a[win];
                    we_d    = bus.req_we[win];
                    len_d   = clamp_len(len_a[win]);
                    cnt_d   = 7'd0;
                end
            end
            CMD: begin
                bus.gnt            = own_oh;
                bus.avm_address    = addr_q;
                bus.avm_burstcount = len_q;
                if (we_q) begin
                    bus.avm_write     = 1'b1;
                    bus.avm_writedata = wdata_a[last_q];
                    if (!bus.avm_waitrequest) begin
                        bus.wr_ack = own_oh;
                        cnt_d      = cnt_q + 7'd1;
                        if (cnt_q == len_q - 7'd1)
                            state_d = IDLE;
                    end
                end else begin
                    bus.avm_read = 1'b1;
                    if (!bus.avm_waitrequest)
                        state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                bus.gnt = own_oh;
                if (bus.avm_readdatavalid) begin
                    bus.rd_valid = own_oh;
                    bus.rd_data  = bus.avm_readdata;
                    cnt_d        = cnt_q + 7'd1;
                    if (cnt_q == len_q - 7'd1)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 2'd2;
            addr_q  <= '0;
            we_q    <= 1'b0;
            len_q   <= 7'd0;
            cnt_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: directed table, hand sequences for alternation and mid-burst reset, random bursts vs a priority model.
module tb_fb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fb_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    fb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .AGE_LIMIT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int mdl_last;

    typedef struct {
        logic [2:0] req;
        logic       urg;
        logic       we;
        logic [6:0] len;
        logic [2:0] exp_gnt;
        int         exp_beats;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req               = 3'b000;
        bus.urgent            = 1'b0;
        bus.req_we            = 3'b000;
        bus.req_addr          = '0;
        bus.req_len           = '0;
        bus.req_wdata         = '0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdata      = '0;
        bus.avm_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Reference: urgent scanout first, otherwise the first requester after the last winner.
    function automatic int mdl_pick(input logic [2:0] rq, input logic urg);
        if (urg && rq[0])
            return 0;
        for (int k = 1; k <= 3; k++)
            if (rq[(mdl_last + k) % 3])
                return (mdl_last + k) % 3;
        return 0;
    endfunction

    function automatic int mdl_len(input int l);
        return (l == 0) ? 1 : ((l > MB) ? MB : l);
    endfunction

    task automatic run_burst(input logic [2:0] rq, input logic urg, input logic [2:0] we,
                             input logic [20:0] lens, input logic [2:0] exp_gnt, input int exp_beats,
                             input int stall_pct, input string tag);
        int own, acks, good, bad, issued, rbeats, c;
        logic [AW-1:0] exp_addr;
        logic          exp_we, ws, v;
        logic [DW-1:0] dat;
        own = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
        acks = 0; good = 0; bad = 0; issued = 0; rbeats = 0; c = 0;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr[i*AW +: AW]  = $urandom;
            bus.req_wdata[i*DW +: DW] = DW'($urandom);
        end
        exp_addr              = bus.req_addr[own*AW +: AW];
        exp_we                = we[own];
        bus.req_we            = we;
        bus.req_len           = lens;
        bus.req               = rq;
        bus.urgent            = urg;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        step();
        // Scramble the requester fields after the grant edge: the command must come from latched values.
        bus.req    = 3'b000;
        bus.urgent = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr[i*AW +: AW] = $urandom;
            bus.req_len[i*7 +: 7]    = 7'($urandom);
        end
        bus.req_we          = ~we;
        bus.avm_waitrequest = 1'b1;
        @(negedge clk);
        check({tag, " gnt"}, bus.gnt, exp_gnt);
        check({tag, " busy"}, bus.busy, 1);
        check({tag, " burstcount"}, bus.avm_burstcount, exp_beats);
        check({tag, " address"}, bus.avm_address, exp_addr);
        check({tag, " command"}, {bus.avm_write, bus.avm_read, bus.wr_ack}, {exp_we, ~exp_we, 3'b000});
        if (exp_we) begin
            while (issued < exp_beats && c < 400) begin
                step(); c++;
                ws  = ($urandom_range(0, 99) < stall_pct);
                dat = DW'($urandom);
                bus.avm_waitrequest             = ws;
                bus.req_wdata[own*DW +: DW] = dat;
                @(negedge clk);
                if (bus.avm_write !== 1'b1 || bus.avm_address !== exp_addr ||
                    bus.avm_writedata !== dat || bus.busy !== 1'b1) bad++;
                if (ws) begin
                    if (bus.wr_ack !== 3'b000) bad++;
                end else begin
                    issued++;
                    if (bus.wr_ack === exp_gnt) acks++;
                    else bad++;
                end
            end
            check({tag, " write acks"}, acks, exp_beats);
        end else begin
            do begin
                step(); c++;
                ws = ($urandom_range(0, 99) < stall_pct);
                bus.avm_waitrequest   = ws;
                bus.avm_readdatavalid = 1'($urandom_range(0, 1));
                bus.avm_readdata      = DW'($urandom);
                @(negedge clk);
                if (bus.avm_read !== 1'b1 || bus.avm_address !== exp_addr || bus.rd_valid !== 3'b000) bad++;
            end while (ws && c < 400);
            while (rbeats < exp_beats && c < 400) begin
                step(); c++;
                v   = ($urandom_range(0, 99) >= stall_pct);
                dat = DW'($urandom);
                bus.avm_waitrequest   = 1'b0;
                bus.avm_readdatavalid = v;
                bus.avm_readdata      = dat;
                @(negedge clk);
                if (bus.avm_read !== 1'b0 || bus.busy !== 1'b1 || bus.gnt !== exp_gnt) bad++;
                if (v) begin
                    rbeats++;
                    if (bus.rd_valid === exp_gnt && bus.rd_data === dat) good++;
                    else bad++;
                end else if (bus.rd_valid !== 3'b000) bad++;
            end
            check({tag, " read beats"}, good, exp_beats);
        end
        step();
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = DW'($urandom);
        @(negedge clk);
        check({tag, " idle after last beat"},
              {bus.busy, bus.gnt, bus.rd_valid, bus.wr_ack, bus.avm_read, bus.avm_write}, 0);
        check({tag, " protocol"}, bad, 0);
        bus.avm_readdatavalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] alt [8];
        int stray;

        tbl[0] = '{3'b010, 1'b0, 1'b1, 7'd4,   3'b010, 4};
        tbl[1] = '{3'b111, 1'b0, 1'b0, 7'd0,   3'b100, 1};
        tbl[2] = '{3'b111, 1'b0, 1'b1, 7'd9,   3'b001, 8};
        tbl[3] = '{3'b111, 1'b1, 1'b0, 7'd8,   3'b001, 8};
        tbl[4] = '{3'b101, 1'b0, 1'b1, 7'd8,   3'b100, 8};
        tbl[5] = '{3'b011, 1'b1, 1'b1, 7'd1,   3'b001, 1};
        tbl[6] = '{3'b110, 1'b1, 1'b0, 7'd127, 3'b010, 8};
        tbl[7] = '{3'b001, 1'b0, 1'b1, 7'd2,   3'b001, 2};
        tbl[8] = '{3'b100, 1'b0, 1'b0, 7'd5,   3'b100, 5};
        alt = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b100};

        idle_inputs();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("reset gnt/acks/valid", {bus.gnt, bus.wr_ack, bus.rd_valid, bus.busy}, 0);
        check("reset avm cmd", {bus.avm_read, bus.avm_write, bus.avm_burstcount}, 0);
        check("reset avm address", bus.avm_address, 0);
        check("reset avm writedata", bus.avm_writedata, 0);
        step();
        reset = 1'b0;

        for (int r = 0; r < 9; r++) begin
            run_burst(tbl[r].req, tbl[r].urg, {3{tbl[r].we}}, {3{tbl[r].len}},
                      tbl[r].exp_gnt, tbl[r].exp_beats, 0, $sformatf("vec%0d", r));
        end

        // Two requesters held high with single-beat writes: grants alternate every other cycle.
        do_reset();
        bus.req_we  = 3'b111;
        bus.req_len = {3{7'd1}};
        bus.req     = 3'b110;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("alternate cycle %0d", k), bus.gnt, alt[k]);
            step();
        end
        bus.req = 3'b000;
        step();
        @(negedge clk);
        check("alternate end busy", bus.busy, 0);

        // Reset on the third beat of an 8-beat scanout read.
        do_reset();
        bus.req_len = {3{7'd8}};
        bus.req     = 3'b001;
        bus.urgent  = 1'b1;
        step();
        bus.req    = 3'b000;
        bus.urgent = 1'b0;
        step();
        for (int b = 0; b < 2; b++) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = DW'(16'h5a00 + b);
            @(negedge clk);
            check($sformatf("pre-reset beat %0d", b), {bus.rd_valid, bus.rd_data}, {3'b001, DW'(16'h5a00 + b)});
            step();
        end
        reset = 1'b1;
        @(negedge clk);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("mid-burst reset flags", {bus.gnt, bus.wr_ack, bus.rd_valid, bus.busy, bus.avm_read, bus.avm_write}, 0);
        check("mid-burst reset bus", {bus.avm_address, bus.avm_writedata, bus.avm_burstcount}, 0);
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            if (bus.rd_valid !== 3'b000 || bus.busy !== 1'b0) stray++;
        end
        check("stray readdatavalid after reset", stray, 0);
        bus.avm_readdatavalid = 1'b0;
        bus.req = 3'b111;
        step();
        bus.req = 3'b000;
        @(negedge clk);
        check("pointer after reset", bus.gnt, 3'b001);

        do_reset();
        mdl_last = 2;
        for (int t = 0; t < 40; t++) begin
            logic [2:0]  rq, we, eg;
            logic        urg;
            logic [20:0] lens;
            int          w, eb;
            rq  = 3'($urandom_range(1, 7));
            urg = 1'($urandom_range(0, 1));
            we  = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++)
                lens[i*7 +: 7] = 7'($urandom_range(0, 12));
            w  = mdl_pick(rq, urg);
            eb = mdl_len(int'(lens[w*7 +: 7]));
            eg = 3'b001 << w;
            mdl_last = w;
            run_burst(rq, urg, we, lens, eg, eb, (t % 4 == 0) ? 70 : 25, $sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
